// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources,
// with a clear sequencer that zeroes every entry one address per cycle.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int PW   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  input  logic [NREQ*PW-1:0]   req_pos_i,
  input  logic                 clear_i,
  output logic                 RegWrite_o,
  output logic [AW-1:0]        RDaddr_o,
  output logic [DW-1:0]        RDdata_o,
  output logic [PW-1:0]        is_pos_o,
  output logic                 busy_o
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state_q;
  logic [PTRW-1:0]   rr_ptr_q;
  logic [AW-1:0]     clr_cnt_q;

  logic [NREQ-1:0]   grant;
  logic [PTRW-1:0]   gnt_idx;
  logic              gnt_any;
  logic              hs;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;
  logic [PW-1:0]     sel_pos;

  // Scan starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    int unsigned     idx;
    logic [PTRW-1:0] cand;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    cand    = '0;
    if (reset_n && (state_q == ARB) && !clear_i) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx  = (32'(rr_ptr_q) + k) % NREQ;
        cand = PTRW'(idx);
        if (!gnt_any && req_valid_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
    end
  end

  assign req_ready_o = grant;
  assign hs          = |(req_valid_i & grant);

  always_comb begin
    sel_addr = req_addr_i[32'(gnt_idx)*AW +: AW];
    sel_data = req_data_i[32'(gnt_idx)*DW +: DW];
    sel_pos  = req_pos_i[32'(gnt_idx)*PW +: PW];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= PTRW'(NREQ - 1);
      clr_cnt_q  <= '0;
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
      is_pos_o   <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (clear_i) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            RegWrite_o <= 1'b0;
            busy_o     <= 1'b1;
          end else if (hs) begin
            RegWrite_o <= 1'b1;
            RDaddr_o   <= sel_addr;
            RDdata_o   <= sel_data;
            is_pos_o   <= sel_pos;
            rr_ptr_q   <= gnt_idx;
          end else begin
            RegWrite_o <= 1'b0;
          end
        end
        CLEAR: begin
          RegWrite_o <= 1'b1;
          RDaddr_o   <= clr_cnt_q;
          RDdata_o   <= '0;
          is_pos_o   <= '0;
          clr_cnt_q  <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= ARB;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: table-driven arbitration vectors plus hand-written clear/reset sequences,
// with a write scoreboard filled at each expected handshake and drained one cycle later.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [14:0] addr_bus;
  logic [95:0] data_bus;
  logic [11:0] pos_bus;
  logic        clear;
  logic        regwrite;
  logic [4:0]  rdaddr;
  logic [31:0] rddata;
  logic [3:0]  ispos;
  logic        busy;

  logic [4:0]  pa [3];
  logic [31:0] pd [3];
  logic [3:0]  pp [3];

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  p;
  } wr_t;

  typedef struct packed {
    logic [2:0] valid;
    logic [2:0] ready;
  } vec_t;

  wr_t   sb[$];
  vec_t  vecs[14];
  int    cnt[3];
  int    checks = 0;
  int    errors = 0;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic [3:0]  last_p;

  assign addr_bus = {pa[2], pa[1], pa[0]};
  assign data_bus = {pd[2], pd[1], pd[0]};
  assign pos_bus  = {pp[2], pp[1], pp[0]};

  regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .PW(4)) dut (
    .clk_i       (clk),
    .reset_n     (reset_n),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_addr_i  (addr_bus),
    .req_data_i  (data_bus),
    .req_pos_i   (pos_bus),
    .clear_i     (clear),
    .RegWrite_o  (regwrite),
    .RDaddr_o    (rdaddr),
    .RDdata_o    (rddata),
    .is_pos_o    (ispos),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
    wr_t e;
    e.a = a; e.d = d; e.p = p;
    sb.push_back(e);
  endtask

  // One clock: check grant/busy mid-cycle, then check the registered write after the edge.
  task automatic cycle(input logic [2:0] exp_ready, input logic exp_busy);
    wr_t e;
    @(negedge clk);
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    for (int i = 0; i < 3; i++)
      if (exp_ready[i]) push(pa[i], pd[i], pp[i]);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wr_strobe", 32'(regwrite), 32'd1);
      chk("wr_addr", 32'(rdaddr), 32'(e.a));
      chk("wr_data", rddata, e.d);
      chk("wr_pos", 32'(ispos), 32'(e.p));
      last_a = e.a; last_d = e.d; last_p = e.p;
    end else begin
      chk("idle_strobe", 32'(regwrite), 32'd0);
      chk("hold_addr", 32'(rdaddr), 32'(last_a));
      chk("hold_data", rddata, last_d);
      chk("hold_pos", 32'(ispos), 32'(last_p));
    end
  endtask

  task automatic set_payloads();
    for (int i = 0; i < 3; i++) begin
      pa[i] = 5'(i * 8 + cnt[i]);
      pd[i] = 32'hC000_0000 | 32'(i << 16) | 32'(cnt[i]);
      pp[i] = 4'(i * 4 + cnt[i]);
    end
  endtask

  initial begin
    vecs[0]  = '{3'b111, 3'b001};
    vecs[1]  = '{3'b110, 3'b010};
    vecs[2]  = '{3'b110, 3'b100};
    vecs[3]  = '{3'b000, 3'b000};
    vecs[4]  = '{3'b010, 3'b010};
    vecs[5]  = '{3'b011, 3'b001};
    vecs[6]  = '{3'b011, 3'b010};
    vecs[7]  = '{3'b101, 3'b100};
    vecs[8]  = '{3'b101, 3'b001};
    vecs[9]  = '{3'b100, 3'b100};
    vecs[10] = '{3'b111, 3'b001};
    vecs[11] = '{3'b111, 3'b010};
    vecs[12] = '{3'b111, 3'b100};
    vecs[13] = '{3'b111, 3'b001};
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    // Reset held with every requester valid
    reset_n = 1'b0; clear = 1'b0; valid = 3'b111;
    set_payloads();
    last_a = '0; last_d = '0; last_p = '0;
    @(posedge clk); #1;
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    reset_n = 1'b1;

    // Arbitration table, starting with the first grant after reset
    for (int n = 0; n < 14; n++) begin
      valid = vecs[n].valid;
      set_payloads();
      cycle(vecs[n].ready, 1'b0);
      for (int i = 0; i < 3; i++)
        if (vecs[n].ready[i]) cnt[i]++;
    end

    // Single request from req1
    valid = 3'b010;
    pa[1] = 5'd5; pd[1] = 32'hDEADBEEF; pp[1] = 4'h3;
    cycle(3'b010, 1'b0);
    valid = 3'b000;
    cycle(3'b000, 1'b0);

    // Same-address conflict after reset: req0 then req2
    reset_n = 1'b0;
    last_a = '0; last_d = '0; last_p = '0;
    cycle(3'b000, 1'b0);
    reset_n = 1'b1;
    valid = 3'b101;
    pa[0] = 5'd7; pd[0] = 32'd1; pp[0] = 4'h1;
    pa[2] = 5'd7; pd[2] = 32'd2; pp[2] = 4'h2;
    cycle(3'b001, 1'b0);
    valid = 3'b100;
    cycle(3'b100, 1'b0);
    valid = 3'b000;
    cycle(3'b000, 1'b0);

    // Clear with req0 waiting; a second clear pulse mid-sequence is ignored
    valid = 3'b001;
    pa[0] = 5'd9; pd[0] = 32'd77; pp[0] = 4'h6;
    clear = 1'b1;
    cycle(3'b000, 1'b0);
    for (int k = 0; k < 32; k++) begin
      clear = (k == 5);
      push(5'(k), 32'd0, 4'd0);
      cycle(3'b000, 1'b1);
    end
    clear = 1'b0;
    cycle(3'b001, 1'b0);
    valid = 3'b000;
    cycle(3'b000, 1'b0);

    // Reset at clr_cnt=10, then a fresh clear restarts at address 0
    clear = 1'b1;
    cycle(3'b000, 1'b0);
    clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(5'(k), 32'd0, 4'd0);
      cycle(3'b000, 1'b1);
    end
    reset_n = 1'b0;
    last_a = '0; last_d = '0; last_p = '0;
    cycle(3'b000, 1'b1);
    reset_n = 1'b1;
    cycle(3'b000, 1'b0);
    clear = 1'b1;
    cycle(3'b000, 1'b0);
    clear = 1'b0;
    for (int k = 0; k < 32; k++) begin
      push(5'(k), 32'd0, 4'd0);
      cycle(3'b000, 1'b1);
    end
    cycle(3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
